// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO of {pc, inst, predictor sideband}.
// Define IF_ID_PRED_EN to store and forward the predictor sideband bits.
module if_id_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  input  logic                       pre_take_or_not_i,
  input  logic                       pre_sel_i,
  output logic                       if_ready,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic                       pre_take_or_not_o,
  output logic                       pre_sel_o,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign if_ready = (count != CNT_W'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end

  always_comb begin
    id_pc   = '0;
    id_inst = '0;
    if (id_valid) begin
      id_pc   = pc_mem[rd_ptr];
      id_inst = inst_mem[rd_ptr];
    end
  end

`ifdef IF_ID_PRED_EN
  logic take_mem [DEPTH];
  logic sel_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      take_mem[wr_ptr] <= pre_take_or_not_i;
      sel_mem[wr_ptr]  <= pre_sel_i;
    end
  end

  always_comb begin
    pre_take_or_not_o = 1'b0;
    pre_sel_o         = 1'b0;
    if (id_valid) begin
      pre_take_or_not_o = take_mem[rd_ptr];
      pre_sel_o         = sel_mem[rd_ptr];
    end
  end
`else
  logic unused_pred;
  assign unused_pred       = pre_take_or_not_i ^ pre_sel_i;
  assign pre_take_or_not_o = 1'b0;
  assign pre_sel_o         = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  logic              clk = 1'b0;
  logic              rst, flush, if_valid, id_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              pre_take_or_not_i, pre_sel_i;
  logic              if_ready, id_valid, pre_take_or_not_o, pre_sel_o;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [$clog2(DEPTH+1)-1:0] count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

`ifdef IF_ID_PRED_EN
  localparam logic PRED_EXP = 1'b1;
`else
  localparam logic PRED_EXP = 1'b0;
`endif

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .pre_take_or_not_i(pre_take_or_not_i), .pre_sel_i(pre_sel_i),
    .if_ready(if_ready), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst),
    .pre_take_or_not_o(pre_take_or_not_o), .pre_sel_o(pre_sel_o),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  task automatic head(input string tag, input logic [ADDR_W-1:0] pc,
                      input logic [INST_W-1:0] inst, input int unsigned cnt);
    check({tag, "_valid"}, 64'(id_valid), 64'(cnt != 0));
    check({tag, "_pc"},    64'(id_pc),    64'(pc));
    check({tag, "_inst"},  64'(id_inst),  64'(inst));
    check({tag, "_count"}, 64'(count),    64'(cnt));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    pre_take_or_not_i = 1'b0; pre_sel_i = 1'b0;
    offer(1'b0, '0, '0);
    #1;
    tick(); tick();
    rst = 1'b0;
    head("reset", '0, '0, 0);
    check("reset_if_ready", 64'(if_ready), 64'd1);
    check("reset_pred", 64'({pre_take_or_not_o, pre_sel_o}), 64'd0);

    // single push, 1-cycle latency, then popped
    id_ready = 1'b1;
    offer(1'b1, 32'h100, 32'h2401_0005);
    tick();
    offer(1'b0, '0, '0);
    head("push1", 32'h100, 32'h2401_0005, 1);
    tick();
    head("pop1", '0, '0, 0);

    // stall ID, fill the queue; 5th offer held by IF
    id_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      offer(1'b1, 32'h200 + 4 * i, 32'hA0 + i);
      tick();
    end
    head("full", 32'h200, 32'hA0, 4);
    check("full_if_ready", 64'(if_ready), 64'd0);
    offer(1'b1, 32'h210, 32'hA4);
    tick();
    head("full_hold", 32'h200, 32'hA0, 4);

    // pop while full: no push that cycle
    id_ready = 1'b1;
    tick();
    head("full_pop", 32'h204, 32'hA1, 3);
    check("full_pop_if_ready", 64'(if_ready), 64'd1);
    // push + pop together: count unchanged
    tick();
    offer(1'b0, '0, '0);
    head("push_pop", 32'h208, 32'hA2, 3);
    tick();
    head("drain1", 32'h20C, 32'hA3, 2);
    tick();
    head("drain_wrap", 32'h210, 32'hA4, 1);
    tick();
    head("drained", '0, '0, 0);

    // flush with count=3 and a same-cycle offer
    id_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      offer(1'b1, 32'h300 + 4 * i, 32'hB0 + i);
      tick();
    end
    head("pre_flush", 32'h300, 32'hB0, 3);
    flush = 1'b1;
    offer(1'b1, 32'h30C, 32'hB3);
    tick();
    flush = 1'b0;
    offer(1'b0, '0, '0);
    head("flush", '0, '0, 0);
    check("flush_if_ready", 64'(if_ready), 64'd1);
    tick();
    head("flush_drop", '0, '0, 0);

    // predictor sideband
    pre_take_or_not_i = 1'b1; pre_sel_i = 1'b1;
    offer(1'b1, 32'h400, 32'hC0);
    tick();
    offer(1'b0, '0, '0);
    pre_take_or_not_i = 1'b0; pre_sel_i = 1'b0;
    head("pred", 32'h400, 32'hC0, 1);
    check("pred_take", 64'(pre_take_or_not_o), 64'(PRED_EXP));
    check("pred_sel",  64'(pre_sel_o),         64'(PRED_EXP));

    // reset mid-stream discards the entry
    rst = 1'b1;
    tick();
    rst = 1'b0;
    head("mid_rst", '0, '0, 0);
    check("mid_rst_pred", 64'({pre_take_or_not_o, pre_sel_o}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
